// File: rtl/bcd_countdown_99.sv
// rtl/bcd_countdown_99.sv - two-digit BCD down-counter with sticky zero flag and terminal-count pulse
// Optional free-running reload at 00 is enabled by defining BCD_CD_AUTORELOAD_EN.
module bcd_countdown_99 #(
  parameter logic [3:0] RST_TENS = 4'd9,
  parameter logic [3:0] RST_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  input  logic       load,
  input  logic [3:0] d_tens,
  input  logic [3:0] d_ones,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic       zero,
  output logic       tc
);

  logic [3:0] rl_tens;
  logic [3:0] rl_ones;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign zero = (y1 == 4'd0) && (y2 == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y1      <= RST_TENS;
      y2      <= RST_ONES;
      rl_tens <= RST_TENS;
      rl_ones <= RST_ONES;
      tc      <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        y1      <= clamp9(d_tens);
        y2      <= clamp9(d_ones);
        rl_tens <= clamp9(d_tens);
        rl_ones <= clamp9(d_ones);
      end else if (x) begin
        if (y2 != 4'd0) begin
          y2 <= y2 - 4'd1;
          // Only the 01 -> 00 step marks terminal count; reloads and holds never do.
          if (y1 == 4'd0 && y2 == 4'd1) tc <= 1'b1;
        end else if (y1 != 4'd0) begin
          y2 <= 4'd9;
          y1 <= y1 - 4'd1;
        end else begin
`ifdef BCD_CD_AUTORELOAD_EN
          y1 <= rl_tens;
          y2 <= rl_ones;
`else
          y1 <= 4'd0;
          y2 <= 4'd0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_99.sv
// tb/tb_bcd_countdown_99.sv - directed self-checking bench for bcd_countdown_99
module tb_bcd_countdown_99;

  logic       clk;
  logic       reset;
  logic       x;
  logic       load;
  logic [3:0] d_tens;
  logic [3:0] d_ones;
  logic [3:0] y1;
  logic [3:0] y2;
  logic       zero;
  logic       tc;

  int checks;
  int failures;

  bcd_countdown_99 dut (
    .clk    (clk),
    .reset  (reset),
    .x      (x),
    .load   (load),
    .d_tens (d_tens),
    .d_ones (d_ones),
    .y1     (y1),
    .y2     (y2),
    .zero   (zero),
    .tc     (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; x = 1'b0; d_tens = t; d_ones = o;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; x = 1'b0; load = 1'b0; d_tens = 4'd0; d_ones = 4'd0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({y1, y2, zero, tc} !== {4'd9, 4'd9, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async: got y=%0d%0d zero=%b tc=%b want 99 0 0", y1, y2, zero, tc);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({y1, y2, zero, tc} !== {4'd9, 4'd9, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_release: got y=%0d%0d zero=%b tc=%b want 99 0 0", y1, y2, zero, tc);
    end
  endtask

  task automatic test_full_countdown;
    int n;
    int tc_count;
    n = 99;
    tc_count = 0;
    x = 1'b1;
    for (int i = 0; i < 99; i++) begin
      tick();
      n = n - 1;
      if (tc === 1'b1) tc_count++;
      checks++;
      if (y1 !== 4'(n / 10) || y2 !== 4'(n % 10) || zero !== (n == 0) || tc !== (n == 0)) begin
        failures++;
        $display("FAIL countdown_step%0d: got y=%0d%0d zero=%b tc=%b want %0d zero=%b tc=%b",
                 i, y1, y2, zero, tc, n, (n == 0), (n == 0));
      end
    end
    checks++;
    if (tc_count !== 1) begin
      failures++;
      $display("FAIL countdown_tc_count: got %0d want 1", tc_count);
    end
  endtask

  task automatic test_hold_zero;
`ifdef BCD_CD_AUTORELOAD_EN
    logic [7:0] seq [8];
    seq = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    do_load(4'd0, 4'd3);
    x = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({y1, y2} !== seq[i] || tc !== (seq[i] == 8'h00) || zero !== (seq[i] == 8'h00)) begin
        failures++;
        $display("FAIL autoreload_step%0d: got y=%0d%0d tc=%b zero=%b want %02h tc=%b",
                 i, y1, y2, tc, zero, seq[i], (seq[i] == 8'h00));
      end
    end
    x = 1'b0;
`else
    x = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({y1, y2, zero, tc} !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL hold_zero_step%0d: got y=%0d%0d zero=%b tc=%b want 00 1 0", i, y1, y2, zero, tc);
      end
    end
    x = 1'b0;
`endif
  endtask

  task automatic test_load_clamp;
    load = 1'b1; x = 1'b0; d_tens = 4'hB; d_ones = 4'h2;
    tick();
    load = 1'b0;
    checks++;
    if ({y1, y2, tc, zero} !== {4'd9, 4'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load_clamp: got y=%0d%0d tc=%b zero=%b want 92 0 0", y1, y2, tc, zero);
    end
    x = 1'b1;
    tick();
    x = 1'b0;
    checks++;
    if ({y1, y2} !== {4'd9, 4'd1}) begin
      failures++;
      $display("FAIL load_clamp_dec: got y=%0d%0d want 91", y1, y2);
    end
    do_load(4'd1, 4'hF);
    checks++;
    if ({y1, y2} !== {4'd1, 4'd9}) begin
      failures++;
      $display("FAIL load_clamp_ones: got y=%0d%0d want 19", y1, y2);
    end
  endtask

  task automatic test_load_and_count;
    do_load(4'd6, 4'd1);
    x = 1'b1;
    tick();
    checks++;
    if ({y1, y2} !== {4'd6, 4'd0}) begin
      failures++;
      $display("FAIL load_count_pre: got y=%0d%0d want 60", y1, y2);
    end
    load = 1'b1; d_tens = 4'd2; d_ones = 4'd5;
    tick();
    load = 1'b0; x = 1'b0;
    checks++;
    if ({y1, y2, tc} !== {4'd2, 4'd5, 1'b0}) begin
      failures++;
      $display("FAIL load_wins: got y=%0d%0d tc=%b want 25 0", y1, y2, tc);
    end
    do_load(4'd0, 4'd1);
    load = 1'b1; x = 1'b1; d_tens = 4'd0; d_ones = 4'd0;
    tick();
    load = 1'b0; x = 1'b0;
    checks++;
    if ({y1, y2, zero, tc} !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL load_no_tc: got y=%0d%0d zero=%b tc=%b want 00 1 0", y1, y2, zero, tc);
    end
  endtask

  task automatic test_tc_drop;
    do_load(4'd0, 4'd1);
    x = 1'b1;
    tick();
    x = 1'b0;
    checks++;
    if ({y1, y2, tc} !== {4'd0, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL tc_pulse: got y=%0d%0d tc=%b want 00 1", y1, y2, tc);
    end
    tick();
    checks++;
    if ({y1, y2, tc, zero} !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL tc_drop: got y=%0d%0d tc=%b zero=%b want 00 0 1", y1, y2, tc, zero);
    end
  endtask

  task automatic test_reset_midcount;
    do_load(4'd4, 4'd7);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({y1, y2, tc} !== {4'd9, 4'd9, 1'b0}) begin
      failures++;
      $display("FAIL reset_midcount: got y=%0d%0d tc=%b want 99 0", y1, y2, tc);
    end
    @(negedge clk);
    reset = 1'b1;
    x = 1'b0;
    tick();
    checks++;
    if ({y1, y2} !== {4'd9, 4'd9}) begin
      failures++;
      $display("FAIL reset_idle: got y=%0d%0d want 99", y1, y2);
    end
    x = 1'b1;
    tick();
    x = 1'b0;
    checks++;
    if ({y1, y2} !== {4'd9, 4'd8}) begin
      failures++;
      $display("FAIL reset_first_dec: got y=%0d%0d want 98", y1, y2);
    end
  endtask

  task automatic test_enable_gating;
    logic [7:0] seq [8];
    seq = '{8'h11, 8'h11, 8'h10, 8'h10, 8'h09, 8'h09, 8'h08, 8'h08};
    do_load(4'd1, 4'd2);
    for (int i = 0; i < 8; i++) begin
      x = (i % 2 == 0);
      tick();
      checks++;
      if ({y1, y2} !== seq[i] || tc !== 1'b0) begin
        failures++;
        $display("FAIL gating_step%0d: got y=%0d%0d tc=%b want %02h 0", i, y1, y2, tc, seq[i]);
      end
    end
    x = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_full_countdown();
    test_hold_zero();
    test_load_clamp();
    test_load_and_count();
    test_tc_drop();
    test_reset_midcount();
    test_enable_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion want finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/bcd_countdown_99.md
# bcd_countdown_99

Two-digit BCD down-counter that is the counterpart of the 00→99 up-counter in the counters lab. It counts from a loaded value (default 99) down to 00 and reports completion with a sticky `zero` flag and a one-cycle `tc` pulse. It is a single-clock registered block that drives the same two-digit display path as the up-counter.

## Interface
- `RST_TENS`, default 9: tens digit loaded on reset (0–9).
- `RST_ONES`, default 9: ones digit loaded on reset (0–9).
- `clk` input, 1 bit: rising-edge clock, the only clock in the block.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `x` input, 1 bit: count enable. The counter decrements once on each rising edge where `x`=1.
- `load` input, 1 bit: synchronous load of `d_tens`/`d_ones`.
- `d_tens` input, 4 bits: BCD tens value to load.
- `d_ones` input, 4 bits: BCD ones value to load.
- `y1` output, 4 bits: current tens digit (registered).
- `y2` output, 4 bits: current ones digit (registered).
- `zero` output, 1 bit: high while `y1`=0 and `y2`=0.
- `tc` output, 1 bit: terminal-count pulse, high for one cycle.

## Operation
- **Reset** (`reset`=0, asynchronous):
  - `y1`=RST_TENS, `y2`=RST_ONES, `tc`=0.
  - `zero`=1 only if both parameters are 0.
  - The reload register is set to RST_TENS/RST_ONES.
- **Priority per edge:** `load` > `x` > hold.
- **Load:**
  - `y1`←`d_tens`, `y2`←`d_ones`.
  - Any digit above 9 is clamped to 9 (for example, 4'hC loads as 9).
  - The clamped value is also written into the reload register.
  - Load never asserts `tc`.
- **Decrement** (`x`=1, `load`=0):
  - If `y2`>0: `y2`←`y2`−1 and `y1` is unchanged.
  - If `y2`=0 and `y1`>0: `y2`←9 and `y1`←`y1`−1 (the borrow).
  - If `y1`=`y2`=0: the behaviour is set by the configuration (hold or reload).
- **`tc`:** registered, high for exactly the one cycle following the edge on which the count moves from 01 to 00. It does not re-pulse while the count is held at 00.
- **`zero`:** decoded from the output registers, so it has no extra latency relative to `y1`/`y2`.
- **Arithmetic:** digit registers only ever hold 0–9, and all arithmetic is per digit. There is no binary-to-BCD conversion.

## Timing
- Every output changes only on a rising `clk` edge or on assertion of `reset`.
- Latency from sampled `x`/`load` to the new `y1`/`y2` is 1 cycle.
- `tc` rises in the same cycle as the 00 value appears on `y1`/`y2`.
- `x` held high from 99 reaches 00 after 99 edges.
- Reset asserted mid-count forces the reset values immediately, without waiting for a clock. The first decrement after reset release happens on the first rising edge with `x`=1.
- `load` and `x` asserted together: the load wins and no decrement is applied on that edge.
- `x` deasserted: all registers hold, and `tc` returns to 0 on the next edge.

## Configuration
- Macro `BCD_CD_AUTORELOAD_EN`.
- **Undefined:**
  - At 00 with `x`=1, the count holds at 00 and `zero` stays 1.
  - Only `load` or `reset` restarts the count.
- **Defined:**
  - At 00 with `x`=1, the count reloads from the reload register on that edge, so the counter is a free-running modulo-(N+1) timer.
  - `zero` is high for one cycle per period while `x` is held.
  - `tc` still marks only the 01→00 transition.
  - A reload value of 00 keeps the count at 00.

## Test plan
- **Reset:** release `reset` with default parameters → `y1`=9, `y2`=9, `zero`=0, `tc`=0. Assert `reset` mid-count at 47 → immediately 99, with no clock edge needed.
- **Full countdown:** hold `x`=1 for 99 edges from 99 → the sequence passes 90→89 and 10→09, reaching 00. `tc`=1 for exactly one cycle and `zero`=1 thereafter.
- **Hold at zero** (macro undefined): 5 further edges with `x`=1 → stays at 00, `tc` stays 0. With the macro defined, load 03, then `x`=1 for 8 edges → the sequence is 02,01,00,03,02,01,00,03, with `tc` pulsing after each 01→00.
- **Load clamp:** `load`=1 with `d_tens`=4'hB, `d_ones`=4'h2 → 92. Next edge with `x`=1 → 91.
- **Load and count together:** `load`=1 and `x`=1 with 25 on the inputs while counting at 60 → 25, not 24 and not 59. `tc` stays 0.
- **Enable gating:** toggle `x` every other cycle from 12 for 8 cycles → 08. Outputs stay stable during `x`=0 cycles.
